calc_display_driver: RTL and testbench
======================================

Name: calc_display_driver

Overview:
- Consumer of the calculator result bus: takes the sign-magnitude result (R, SR) and the operating-state code (Sestado).
- Converts the 16-bit magnitude to 5 BCD digits with a sequential double-dabble engine.
- Drives a 6-digit multiplexed, active-low 7-segment display: digits 0-4 show the magnitude, digit 5 shows the sign.
- Sits between the arithmetic core and the board display pins.

Parameters:
SCAN_DIV, 50000, clock cycles each digit stays enabled before the scan advances (minimum 2).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset
R  in  16  result magnitude
SR  in  1  result sign, 1 = negative
Sestado  in  3  calculator state code; 0 = Desligado, all others = on
an  out  6  digit enables, active-low one-hot; an[0] = least-significant digit
seg  out  7  segments, active-low, seg[6:0] = {g,f,e,d,c,b,a}
bcd  out  20  last completed conversion, bcd[3:0] = units
bcd_valid  out  1  at least one conversion has completed since reset
busy  out  1  conversion in progress

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - bcd=0, bcd_valid=0, busy=0.
  - an=6'b111110, seg=7'h7F.
  - Scan counter=0, digit index=0.
  - Shadow registers {state,sign,mag}=0.
  - FSM=IDLE, pending=1, so one conversion always runs after reset.
- Change detection:
  - In IDLE, if pending=1 or {Sestado,SR,R} differs from the shadow, the shadow loads the inputs, pending clears, and the FSM goes to LOAD.
  - Input changes while busy are ignored. They are re-compared on return to IDLE, so the latest value is never lost and intermediate values may be skipped.
- FSM sequence: IDLE -> LOAD -> (ADJ -> SHIFT) x16 -> DONE -> IDLE.
  - LOAD: 36-bit work register = {20'b0, shadow mag}; iteration count = 0.
  - ADJ: add 3 to each BCD nibble >= 5.
  - SHIFT: shift the work register left 1; count +1; after the 16th SHIFT go to DONE, otherwise go to ADJ.
  - DONE: bcd <= work[35:16]; disp_state/disp_sign <= shadow state/sign; bcd_valid <= 1.
  - busy=1 in every state except IDLE.
  - Latency: 34 clocks from the edge entering LOAD to bcd updating. A new conversion can start on the cycle after DONE.
- bcd holds the last completed result and never shows partial work. bcd_valid stays 1 until reset.
- Input range: max magnitude 65535, which fits 5 digits. No overflow case exists.
- Display scan:
  - The counter counts 0..SCAN_DIV-1. On wrap, the digit index advances 0->5, then wraps to 0.
  - an = ~(6'b1 << index).
  - an and seg are registered and update together.
- Digit content:
  - bcd_valid=0 or disp_state=0: all digits blank (7'h7F); scanning continues.
  - Digit 0: always shown.
  - Digits 1-4: blank when that digit and every higher magnitude digit are 0 (leading-zero blanking only; interior zeros are shown).
  - Digit 5: '-' (7'h3F) when disp_sign=1 and magnitude != 0; otherwise blank. Negative zero therefore displays "0".
- Segment codes, active-low:
  - 0:40, 1:79, 2:24, 3:30, 4:19
  - 5:12, 6:02, 7:78, 8:00, 9:10
- Reset mid-conversion: immediately returns to reset values. The partial result is discarded and a fresh conversion runs after release.

Test Plan:
- Reset, release with R=0, SR=0, Sestado=1, SCAN_DIV=4 -> busy rises; 34 clocks after LOAD: bcd=20'h00000, bcd_valid=1. Scan shows digit0 seg=40; digits 1-5 seg=7F; an cycles 111110..011111 every 4 clocks.
- R=65025, SR=1, Sestado=3 -> bcd=20'h65025. Digits 0-4 seg=12,24,40,12,02 (5,2,0,5,6); digit5 seg=3F.
- R=100, SR=0, Sestado=2 -> bcd=20'h00100. Digits 0-2 seg=40,40,79; digits 3-5 seg=7F.
- R=7 starts a conversion; during busy R=1234, then R=4321 -> bcd goes 20'h00007, then 20'h04321. Exactly two conversions run; 20'h01234 never appears.
- R=5, Sestado=0 -> after conversion, all digits seg=7F. Then R=0, SR=1, Sestado=4 -> digit0 seg=40, digit5 blank.
- rst_n low at the 10th cycle of a conversion -> same cycle: busy=0, bcd_valid=0, bcd=0, an=111110, seg=7F. After release, a conversion of the current inputs completes in 34 clocks.

Source files
------------

// File: rtl/calc_display_driver.sv
`default_nettype none
// ============================================================================
//  Module      : calc_display_driver
//  Description : Converts the calculator's sign-magnitude result to BCD with a
//                sequential double-dabble engine and drives a 6-digit
//                multiplexed active-low 7-segment display (digits 0-4 show
//                the magnitude, digit 5 shows the sign).
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_display_driver #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] R,
  input  logic        SR,
  input  logic [2:0]  Sestado,
  output logic [5:0]  an,
  output logic [6:0]  seg,
  output logic [19:0] bcd,
  output logic        bcd_valid,
  output logic        busy
);

  localparam int              CNT_W      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(SCAN_DIV - 1);
  localparam logic [4:0]       c_last_shift = 5'd15;
  localparam logic [6:0]       c_seg_blank  = 7'h7F;
  localparam logic [6:0]       c_seg_minus  = 7'h3F;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ADJ   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Shadow copy of the inputs being (or last) converted
  logic        r_pending;
  logic [2:0]  r_sh_state;
  logic        r_sh_sign;
  logic [15:0] r_sh_mag;
  logic        w_change;

  // Double-dabble datapath: [35:16] BCD digits, [15:0] binary being shifted in
  logic [35:0] r_work;
  logic [4:0]  r_count;
  logic [19:0] w_adj;

  // Published result and the state/sign that belong to it
  logic [19:0] r_bcd;
  logic        r_bcd_valid;
  logic [2:0]  r_disp_state;
  logic        r_disp_sign;

  // Display scan
  logic [CNT_W-1:0] r_scan_cnt;
  logic [2:0]       r_idx;
  logic [2:0]       w_idx_next;
  logic             w_wrap;
  logic [5:0]       r_an;
  logic [6:0]       r_seg;
  logic [6:0]       w_seg_next;
  logic [4:0]       w_nz;
  logic [4:0]       w_show;

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign w_change = r_pending ||
                    ({Sestado, SR, R} != {r_sh_state, r_sh_sign, r_sh_mag});

  // Add-3 correction for every BCD nibble that would overflow on the next shift
  for (genvar gi = 0; gi < 5; gi++) begin : g_adj
    assign w_adj[4*gi +: 4] = (r_work[16 + 4*gi +: 4] >= 4'd5) ?
                              (r_work[16 + 4*gi +: 4] + 4'd3) :
                              r_work[16 + 4*gi +: 4];
  end

  // Per-digit non-zero flags for leading-zero blanking
  for (genvar gi = 0; gi < 5; gi++) begin : g_nz
    assign w_nz[gi] = |r_bcd[4*gi +: 4];
  end

  assign w_show[0] = 1'b1;
  assign w_show[1] = |w_nz[4:1];
  assign w_show[2] = |w_nz[4:2];
  assign w_show[3] = |w_nz[4:3];
  assign w_show[4] = w_nz[4];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next-state logic and busy flag
  always_comb begin
    w_state_next = r_state;
    busy         = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (w_change) w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_ADJ;
      S_ADJ:   w_state_next = S_SHIFT;
      S_SHIFT: w_state_next = (r_count == c_last_shift) ? S_DONE : S_ADJ;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Capture the inputs when a conversion is launched; changes while busy wait
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending  <= 1'b1;
      r_sh_state <= 3'd0;
      r_sh_sign  <= 1'b0;
      r_sh_mag   <= 16'd0;
    end else if (r_state == S_IDLE && w_change) begin
      r_pending  <= 1'b0;
      r_sh_state <= Sestado;
      r_sh_sign  <= SR;
      r_sh_mag   <= R;
    end
  end

  // Double-dabble work register and iteration counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work  <= 36'd0;
      r_count <= 5'd0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_work  <= {20'd0, r_sh_mag};
          r_count <= 5'd0;
        end
        S_ADJ:   r_work <= {w_adj, r_work[15:0]};
        S_SHIFT: begin
          r_work  <= {r_work[34:0], 1'b0};
          r_count <= r_count + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Publish a finished conversion atomically with its state and sign
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd        <= 20'd0;
      r_bcd_valid  <= 1'b0;
      r_disp_state <= 3'd0;
      r_disp_sign  <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_bcd        <= r_work[35:16];
      r_bcd_valid  <= 1'b1;
      r_disp_state <= r_sh_state;
      r_disp_sign  <= r_sh_sign;
    end
  end

  assign w_wrap     = (r_scan_cnt == c_cnt_last);
  assign w_idx_next = !w_wrap ? r_idx : ((r_idx == 3'd5) ? 3'd0 : (r_idx + 3'd1));

  // Scan timer and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_idx      <= 3'd0;
    end else begin
      r_scan_cnt <= w_wrap ? '0 : (r_scan_cnt + CNT_W'(1));
      r_idx      <= w_idx_next;
    end
  end

  // Segment pattern for the digit about to be enabled
  always_comb begin
    w_seg_next = c_seg_blank;
    if (r_bcd_valid && r_disp_state != 3'd0) begin
      case (w_idx_next)
        3'd0: w_seg_next = f_seg(r_bcd[3:0]);
        3'd1: if (w_show[1]) w_seg_next = f_seg(r_bcd[7:4]);
        3'd2: if (w_show[2]) w_seg_next = f_seg(r_bcd[11:8]);
        3'd3: if (w_show[3]) w_seg_next = f_seg(r_bcd[15:12]);
        3'd4: if (w_show[4]) w_seg_next = f_seg(r_bcd[19:16]);
        3'd5: if (r_disp_sign && (|r_bcd)) w_seg_next = c_seg_minus;
        default: w_seg_next = c_seg_blank;
      endcase
    end
  end

  // Digit enable and segments registered together so they never disagree
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= 6'b111110;
      r_seg <= c_seg_blank;
    end else begin
      r_an  <= ~(6'b000001 << w_idx_next);
      r_seg <= w_seg_next;
    end
  end

  assign an        = r_an;
  assign seg       = r_seg;
  assign bcd       = r_bcd;
  assign bcd_valid = r_bcd_valid;

endmodule
`default_nettype wire

// File: tb/tb_calc_display_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_calc_display_driver
//  Description : Directed, table-driven bench for calc_display_driver with
//                hand-computed BCD and segment expectations (SCAN_DIV = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_display_driver;

  logic        clk;
  logic        rst_n;
  logic [15:0] R;
  logic        SR;
  logic [2:0]  Sestado;
  logic [5:0]  an;
  logic [6:0]  seg;
  logic [19:0] bcd;
  logic        bcd_valid;
  logic        busy;

  int total = 0;
  int bad   = 0;

  calc_display_driver #(.SCAN_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .R         (R),
    .SR        (SR),
    .Sestado   (Sestado),
    .an        (an),
    .seg       (seg),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Segment expectations packed as {d5,d4,d3,d2,d1,d0}
  typedef struct packed {
    logic [15:0]     r;
    logic            sr;
    logic [2:0]      st;
    logic [19:0]     exp_bcd;
    logic [5:0][6:0] exp_seg;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walk all six digit positions and compare each one's segments
  task automatic sweep(input string tag, input logic [5:0][6:0] exp);
    logic [5:0] want;
    int n;
    for (int d = 0; d < 6; d++) begin
      want = ~(6'b000001 << d);
      n = 0;
      while (an !== want && n < 50) begin
        step();
        n++;
      end
      if (n >= 50) begin
        total++;
        bad++;
        $display("FAIL %s_scan%0d: an=%b never reached %b", tag, d, an, want);
      end else begin
        chk($sformatf("%s_seg%0d", tag, d), {25'd0, seg}, {25'd0, exp[d]});
      end
    end
  endtask

  // From reset release: count edges until the first result is published
  task automatic measure_load(input string tag, input logic [19:0] exp_bcd);
    int n;
    n = 0;
    do begin
      step();
      n++;
      if (n == 1) chk({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
    end while (!bcd_valid && n < 100);
    chk({tag, "_latency"}, n, 35);
    chk({tag, "_bcd"}, {12'd0, bcd}, {12'd0, exp_bcd});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   rises;
    logic prev_busy;
    logic [19:0] prev_bcd;
    logic [19:0] first_change;
    logic saw_first;
    logic saw_1234;

    vecs[0] = '{16'd65025, 1'b1, 3'd3, 20'h65025, {7'h3F, 7'h02, 7'h12, 7'h40, 7'h24, 7'h12}};
    vecs[1] = '{16'd100,   1'b0, 3'd2, 20'h00100, {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40}};
    vecs[2] = '{16'd5,     1'b0, 3'd0, 20'h00005, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F}};
    vecs[3] = '{16'd0,     1'b1, 3'd4, 20'h00000, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[4] = '{16'd9,     1'b1, 3'd1, 20'h00009, {7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h10}};
    vecs[5] = '{16'd10203, 1'b0, 3'd1, 20'h10203, {7'h7F, 7'h79, 7'h40, 7'h24, 7'h40, 7'h30}};
    vecs[6] = '{16'd65535, 1'b0, 3'd7, 20'h65535, {7'h7F, 7'h02, 7'h12, 7'h12, 7'h30, 7'h12}};
    vecs[7] = '{16'd4678,  1'b1, 3'd5, 20'h04678, {7'h3F, 7'h7F, 7'h19, 7'h02, 7'h78, 7'h00}};

    // Reset state
    rst_n = 1'b0; R = 16'd0; SR = 1'b0; Sestado = 3'd1;
    repeat (3) step();
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_valid", {31'd0, bcd_valid}, 32'd0);
    chk("rst_bcd",   {12'd0, bcd},       32'd0);
    chk("rst_an",    {26'd0, an},        32'h3E);
    chk("rst_seg",   {25'd0, seg},       32'h7F);

    // First conversion after release runs even though inputs equal the shadow
    rst_n = 1'b1;
    measure_load("first", 20'h00000);
    chk("first_valid", {31'd0, bcd_valid}, 32'd1);
    sweep("zero", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});

    // Each digit stays enabled for SCAN_DIV clocks
    n = 0;
    while (an !== 6'b111101 && n < 50) begin step(); n++; end
    chk("dwell_reach", {31'd0, (n < 50)}, 32'd1);
    n = 0;
    while (an === 6'b111101 && n < 20) begin step(); n++; end
    chk("dwell_len", n, 4);
    chk("dwell_next_an", {26'd0, an}, 32'h3B);

    // Table of conversions
    for (int i = 0; i < 8; i++) begin
      R = vecs[i].r; SR = vecs[i].sr; Sestado = vecs[i].st;
      step();
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
      n = 0;
      while (busy && n < 100) begin step(); n++; end
      chk($sformatf("v%0d_conv_len", i), n, 34);
      chk($sformatf("v%0d_bcd", i), {12'd0, bcd}, {12'd0, vecs[i].exp_bcd});
      chk($sformatf("v%0d_valid", i), {31'd0, bcd_valid}, 32'd1);
      sweep($sformatf("v%0d", i), vecs[i].exp_seg);
    end

    // Input changes while busy are coalesced to the latest value
    R = 16'd7; SR = 1'b0; Sestado = 3'd1;
    rises = 0; prev_busy = busy; prev_bcd = bcd;
    saw_first = 1'b0; saw_1234 = 1'b0; first_change = 20'hFFFFF;
    for (int i = 0; i < 120; i++) begin
      step();
      if (i == 3)  R = 16'd1234;
      if (i == 12) R = 16'd4321;
      if (busy && !prev_busy) rises++;
      if (bcd !== prev_bcd) begin
        if (!saw_first) begin
          first_change = bcd;
          saw_first = 1'b1;
        end
        if (bcd === 20'h01234) saw_1234 = 1'b1;
      end
      prev_busy = busy;
      prev_bcd  = bcd;
    end
    chk("coal_first",  {12'd0, first_change}, 32'h00007);
    chk("coal_final",  {12'd0, bcd},          32'h04321);
    chk("coal_rises",  rises,                 2);
    chk("coal_no1234", {31'd0, saw_1234},     32'd0);
    chk("coal_idle",   {31'd0, busy},         32'd0);

    // Reset asserted on the 10th cycle of a conversion
    R = 16'd999;
    step();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    repeat (9) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  {31'd0, busy},      32'd0);
    chk("mid_rst_valid", {31'd0, bcd_valid}, 32'd0);
    chk("mid_rst_bcd",   {12'd0, bcd},       32'd0);
    chk("mid_rst_an",    {26'd0, an},        32'h3E);
    chk("mid_rst_seg",   {25'd0, seg},       32'h7F);
    step();
    rst_n = 1'b1;
    measure_load("after_rst", 20'h00999);
    sweep("after_rst", {7'h7F, 7'h7F, 7'h7F, 7'h10, 7'h10, 7'h10});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
